ravenoc_ni_tx: RTL and testbench

- Local-port injector that sits at the far end of a router's local input.
- Takes one packet request (destination X/Y plus payload word count) and a stream of payload words.
- Emits wormhole flits (head, body..., tail) toward the router's local receive side using valid/ready flow control.
- It is the sending counterpart of the router input stage that decodes head flits and routes them.

---
 rtl/ravenoc_ni_tx.sv | 173 +++++++++++++++++
 tb/tb_ravenoc_ni_tx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ravenoc_ni_tx.sv
// Network-interface injector: turns a packet request plus a payload stream into
// HEAD/BODY/TAIL wormhole flits. Define RAVENOC_NI_DEST_CHECK_EN to drop out-of-mesh requests.
module ravenoc_ni_tx #(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int X_WIDTH         = 2,
    parameter int Y_WIDTH         = 2,
    parameter int PKT_LEN_WIDTH   = 8,
    parameter int NOC_ROWS        = 2,
    parameter int NOC_COLS        = 2
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       pkt_valid_i,
    output logic                       pkt_ready_o,
    input  logic [X_WIDTH-1:0]         pkt_x_dest_i,
    input  logic [Y_WIDTH-1:0]         pkt_y_dest_i,
    input  logic [PKT_LEN_WIDTH-1:0]   pkt_len_i,
    input  logic                       data_valid_i,
    input  logic [FLIT_DATA_WIDTH-1:0] data_i,
    output logic                       data_ready_o,
    output logic                       flit_valid_o,
    output logic [FLIT_DATA_WIDTH+1:0] flit_o,
    input  logic                       flit_ready_i,
    output logic                       busy_o,
    output logic                       err_o
);

    localparam int FLIT_WIDTH = FLIT_DATA_WIDTH + 2;
    localparam int HDR_WIDTH  = X_WIDTH + Y_WIDTH + PKT_LEN_WIDTH;

    localparam logic [1:0] FLIT_HEAD      = 2'b00;
    localparam logic [1:0] FLIT_BODY      = 2'b01;
    localparam logic [1:0] FLIT_TAIL      = 2'b10;
    localparam logic [1:0] FLIT_HEAD_ONLY = 2'b11;

    localparam logic [PKT_LEN_WIDTH-1:0] CNT_ONE = PKT_LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1
`ifdef RAVENOC_NI_DEST_CHECK_EN
        ,
        ST_DROP    = 2'd2
`endif
    } state_t;

    state_t                     state_q, state_d;
    logic [PKT_LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic                       flit_valid_q, flit_valid_d;
    logic [FLIT_WIDTH-1:0]      flit_q, flit_d;
    logic                       can_load;
    logic                       load_head;
    logic                       pkt_has_payload;
    logic [FLIT_DATA_WIDTH-1:0] head_data;

    // NOTE: the output register may only be overwritten once its current flit is
    // taken (or it is empty); otherwise a stalled flit would change under the router.
    assign can_load        = !flit_valid_q || flit_ready_i;
    assign pkt_has_payload = (pkt_len_i != '0);
    assign head_data       = {pkt_x_dest_i, pkt_y_dest_i, pkt_len_i,
                              {(FLIT_DATA_WIDTH-HDR_WIDTH){1'b0}}};

`ifdef RAVENOC_NI_DEST_CHECK_EN
    localparam logic [X_WIDTH:0] X_LIMIT = (X_WIDTH+1)'(NOC_ROWS);
    localparam logic [Y_WIDTH:0] Y_LIMIT = (Y_WIDTH+1)'(NOC_COLS);

    logic dest_bad;
    logic err_q, err_d;

    assign dest_bad = ({1'b0, pkt_x_dest_i} >= X_LIMIT) || ({1'b0, pkt_y_dest_i} >= Y_LIMIT);
`endif

    // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flit_d       = flit_q;
        flit_valid_d = flit_valid_q && !flit_ready_i;
        pkt_ready_o  = 1'b0;
        data_ready_o = 1'b0;
        load_head    = 1'b0;
`ifdef RAVENOC_NI_DEST_CHECK_EN
        err_d        = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                // Readies are masked while arst is held so every output reads 0 in reset.
                pkt_ready_o = can_load && !arst;
                if (pkt_valid_i && pkt_ready_o) begin
                    cnt_d = pkt_len_i;
`ifdef RAVENOC_NI_DEST_CHECK_EN
                    if (dest_bad) begin
                        err_d   = 1'b1;
                        state_d = pkt_has_payload ? ST_DROP : ST_IDLE;
                    end else begin
                        load_head = 1'b1;
                    end
`else
                    load_head = 1'b1;
`endif
                    if (load_head) begin
                        flit_valid_d = 1'b1;
                        flit_d       = {pkt_has_payload ? FLIT_HEAD : FLIT_HEAD_ONLY, head_data};
                        state_d      = pkt_has_payload ? ST_PAYLOAD : ST_IDLE;
                    end
                end
            end

            ST_PAYLOAD: begin
                data_ready_o = can_load && !arst;
                if (data_valid_i && data_ready_o) begin
                    flit_valid_d = 1'b1;
                    flit_d       = {(cnt_q == CNT_ONE) ? FLIT_TAIL : FLIT_BODY, data_i};
                    cnt_d        = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_IDLE;
                    end
                end
            end

`ifdef RAVENOC_NI_DEST_CHECK_EN
            ST_DROP: begin
                data_ready_o = !arst;
                if (data_valid_i && data_ready_o) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_IDLE;
                    end
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            flit_valid_q <= 1'b0;
            flit_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flit_valid_q <= flit_valid_d;
            flit_q       <= flit_d;
        end
    end

`ifdef RAVENOC_NI_DEST_CHECK_EN
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign flit_valid_o = flit_valid_q;
    assign flit_o       = flit_q;
    assign busy_o       = (state_q != ST_IDLE) || flit_valid_q;

endmodule

// File: tb/tb_ravenoc_ni_tx.sv
// Self-checking bench for ravenoc_ni_tx: cycle vector table plus hand-written
// reset and (with RAVENOC_NI_DEST_CHECK_EN) drop sequences.
module tb_ravenoc_ni_tx;

    localparam int DW = 32;
    localparam logic [1:0] T_HEAD      = 2'b00;
    localparam logic [1:0] T_BODY      = 2'b01;
    localparam logic [1:0] T_TAIL      = 2'b10;
    localparam logic [1:0] T_HEAD_ONLY = 2'b11;
    localparam int N_VEC = 21;

    logic          clk = 1'b0;
    logic          arst;
    logic          pkt_valid_i;
    logic          pkt_ready_o;
    logic [1:0]    pkt_x_dest_i;
    logic [1:0]    pkt_y_dest_i;
    logic [7:0]    pkt_len_i;
    logic          data_valid_i;
    logic [DW-1:0] data_i;
    logic          data_ready_o;
    logic          flit_valid_o;
    logic [DW+1:0] flit_o;
    logic          flit_ready_i;
    logic          busy_o;
    logic          err_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ravenoc_ni_tx dut (
        .clk          (clk),
        .arst         (arst),
        .pkt_valid_i  (pkt_valid_i),
        .pkt_ready_o  (pkt_ready_o),
        .pkt_x_dest_i (pkt_x_dest_i),
        .pkt_y_dest_i (pkt_y_dest_i),
        .pkt_len_i    (pkt_len_i),
        .data_valid_i (data_valid_i),
        .data_i       (data_i),
        .data_ready_o (data_ready_o),
        .flit_valid_o (flit_valid_o),
        .flit_o       (flit_o),
        .flit_ready_i (flit_ready_i),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    // One clock of stimulus: readies checked before the edge, registered outputs after it.
    typedef struct {
        logic          pv;
        logic [1:0]    px;
        logic [1:0]    py;
        logic [7:0]    pl;
        logic          dv;
        logic [DW-1:0] dd;
        logic          fr;
        logic          e_pr;
        logic          e_dr;
        logic          e_fv;
        logic [DW+1:0] e_fl;
        logic          e_busy;
    } vec_t;

    vec_t vecs[N_VEC];

    function automatic logic [DW+1:0] head(input logic [1:0] t, input logic [1:0] x,
                                          input logic [1:0] y, input logic [7:0] n);
        return {t, x, y, n, 20'h0};
    endfunction

    function automatic logic [DW+1:0] dflit(input logic [1:0] t, input logic [DW-1:0] d);
        return {t, d};
    endfunction

    function automatic vec_t mk(input logic pv, input logic [1:0] px, input logic [1:0] py,
                                input logic [7:0] pl, input logic dv, input logic [DW-1:0] dd,
                                input logic fr, input logic e_pr, input logic e_dr,
                                input logic e_fv, input logic [DW+1:0] e_fl, input logic e_busy);
        vec_t v;
        v.pv = pv; v.px = px; v.py = py; v.pl = pl; v.dv = dv; v.dd = dd; v.fr = fr;
        v.e_pr = e_pr; v.e_dr = e_dr; v.e_fv = e_fv; v.e_fl = e_fl; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        pkt_valid_i  = 1'b0;
        pkt_x_dest_i = '0;
        pkt_y_dest_i = '0;
        pkt_len_i    = '0;
        data_valid_i = 1'b0;
        data_i       = '0;
        flit_ready_i = 1'b1;
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        pkt_valid_i  = v.pv;
        pkt_x_dest_i = v.px;
        pkt_y_dest_i = v.py;
        pkt_len_i    = v.pl;
        data_valid_i = v.dv;
        data_i       = v.dd;
        flit_ready_i = v.fr;
        #1;
        check({tag, " pkt_ready"}, 64'(pkt_ready_o), 64'(v.e_pr));
        check({tag, " data_ready"}, 64'(data_ready_o), 64'(v.e_dr));
        @(posedge clk);
        #1;
        check({tag, " flit_valid"}, 64'(flit_valid_o), 64'(v.e_fv));
        check({tag, " busy"}, 64'(busy_o), 64'(v.e_busy));
        if (v.e_fv) begin
            check({tag, " flit"}, 64'(flit_o), 64'(v.e_fl));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        arst = 1'b1;
        drive_idle();

        // pv  x  y  len dv  data       fr  pr dr fv  flit                          busy
        vecs[0]  = mk(1, 1, 0, 0, 0, 0,        1,  1, 0, 1, head(T_HEAD_ONLY, 1, 0, 0), 1);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0,        1,  1, 0, 0, '0,                         0);
        vecs[2]  = mk(1, 0, 1, 3, 0, 0,        1,  1, 0, 1, head(T_HEAD, 0, 1, 3),      1);
        vecs[3]  = mk(0, 0, 0, 0, 1, 32'hA,    1,  0, 1, 1, dflit(T_BODY, 32'hA),       1);
        vecs[4]  = mk(0, 0, 0, 0, 1, 32'hB,    1,  0, 1, 1, dflit(T_BODY, 32'hB),       1);
        vecs[5]  = mk(0, 0, 0, 0, 1, 32'hC,    1,  0, 1, 1, dflit(T_TAIL, 32'hC),       1);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0,        1,  1, 0, 0, '0,                         0);
        vecs[7]  = mk(1, 1, 1, 2, 0, 0,        1,  1, 0, 1, head(T_HEAD, 1, 1, 2),      1);
        vecs[8]  = mk(0, 0, 0, 0, 1, 32'h11,   1,  0, 1, 1, dflit(T_BODY, 32'h11),      1);
        vecs[9]  = mk(1, 1, 0, 5, 1, 32'h22,   0,  0, 0, 1, dflit(T_BODY, 32'h11),      1);
        vecs[10] = mk(1, 1, 0, 5, 1, 32'h22,   0,  0, 0, 1, dflit(T_BODY, 32'h11),      1);
        vecs[11] = mk(1, 1, 0, 5, 1, 32'h22,   0,  0, 0, 1, dflit(T_BODY, 32'h11),      1);
        vecs[12] = mk(0, 0, 0, 0, 1, 32'h22,   1,  0, 1, 1, dflit(T_TAIL, 32'h22),      1);
        vecs[13] = mk(0, 0, 0, 0, 0, 0,        1,  1, 0, 0, '0,                         0);
        vecs[14] = mk(1, 0, 0, 1, 0, 0,        1,  1, 0, 1, head(T_HEAD, 0, 0, 1),      1);
        vecs[15] = mk(0, 0, 0, 0, 1, 32'h5A,   1,  0, 1, 1, dflit(T_TAIL, 32'h5A),      1);
        vecs[16] = mk(1, 1, 1, 1, 0, 0,        1,  1, 0, 1, head(T_HEAD, 1, 1, 1),      1);
        vecs[17] = mk(0, 0, 0, 0, 1, 32'hA5,   1,  0, 1, 1, dflit(T_TAIL, 32'hA5),      1);
        vecs[18] = mk(1, 0, 1, 0, 1, 32'h77,   0,  0, 0, 1, dflit(T_TAIL, 32'hA5),      1);
        vecs[19] = mk(0, 0, 0, 0, 1, 32'h77,   1,  1, 0, 0, '0,                         0);
        vecs[20] = mk(0, 0, 0, 0, 0, 0,        1,  1, 0, 0, '0,                         0);

        #2;
        check("reset flit_valid", 64'(flit_valid_o), 64'd0);
        check("reset flit", 64'(flit_o), 64'd0);
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset pkt_ready", 64'(pkt_ready_o), 64'd0);
        check("reset data_ready", 64'(data_ready_o), 64'd0);
        check("reset err", 64'(err_o), 64'd0);
        @(negedge clk);
        arst = 1'b0;

        for (int i = 0; i < N_VEC; i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
            check($sformatf("v%0d err", i), 64'(err_o), 64'd0);
        end

        // Reset in the middle of an N=4 packet, after the head and one body flit.
        apply(mk(1, 1, 0, 4, 0, 0,      1, 1, 0, 1, head(T_HEAD, 1, 0, 4), 1), "rst head");
        apply(mk(0, 0, 0, 0, 1, 32'h100, 1, 0, 1, 1, dflit(T_BODY, 32'h100), 1), "rst body");
        @(negedge clk);
        data_valid_i = 1'b1;
        data_i       = 32'h200;
        arst         = 1'b1;
        #1;
        check("mid rst flit_valid", 64'(flit_valid_o), 64'd0);
        check("mid rst busy", 64'(busy_o), 64'd0);
        check("mid rst data_ready", 64'(data_ready_o), 64'd0);
        check("mid rst pkt_ready", 64'(pkt_ready_o), 64'd0);
        @(negedge clk);
        arst = 1'b0;
        drive_idle();
        #1;
        check("post rst pkt_ready", 64'(pkt_ready_o), 64'd1);
        check("post rst busy", 64'(busy_o), 64'd0);
        apply(mk(1, 0, 1, 1, 0, 0,       1, 1, 0, 1, head(T_HEAD, 0, 1, 1), 1), "after rst head");
        apply(mk(0, 0, 0, 0, 1, 32'h300, 1, 0, 1, 1, dflit(T_TAIL, 32'h300), 1), "after rst tail");
        apply(mk(0, 0, 0, 0, 0, 0,       1, 1, 0, 0, '0, 0), "after rst idle");

`ifdef RAVENOC_NI_DEST_CHECK_EN
        // X=3 is outside a 2-row mesh: request accepted, payload swallowed, no flits.
        apply(mk(1, 3, 0, 2, 0, 0,       1, 1, 0, 0, '0, 1), "drop req");
        check("drop err pulse", 64'(err_o), 64'd1);
        apply(mk(0, 0, 0, 0, 1, 32'hD0, 1, 0, 1, 0, '0, 1), "drop w0");
        check("drop err end", 64'(err_o), 64'd0);
        apply(mk(0, 0, 0, 0, 1, 32'hD1, 1, 0, 1, 0, '0, 0), "drop w1");
        check("drop err quiet", 64'(err_o), 64'd0);
        apply(mk(1, 0, 1, 0, 0, 0,       1, 1, 0, 1, head(T_HEAD_ONLY, 0, 1, 0), 1), "after drop");
        check("after drop err", 64'(err_o), 64'd0);
`endif

        drive_idle();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
